// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one unified memory port between the fetch stage (instruction reads)
//   and the memory stage (data loads/stores). One transaction is outstanding at
//   a time. Data accesses normally win; a starvation counter forces a fetch
//   grant after STARVE_LIMIT consecutive contested data wins.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-low reset
//   if_req_i/if_addr_i      fetch read request
//   if_gnt_o                fetch accepted (combinational, one-cycle pulse)
//   if_rvalid_o/if_rdata_o  fetch response (registered pulse / held data)
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data load/store request
//   dm_gnt_o                data accepted (combinational, one-cycle pulse)
//   dm_rvalid_o/dm_rdata_o  load data / store done (registered pulse / held data)
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  request to memory
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i         memory handshake and response
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     if_req_i,
    input  logic [ADDRESS_WIDTH-1:0] if_addr_i,
    output logic                     if_gnt_o,
    output logic                     if_rvalid_o,
    output logic [DATA_WIDTH-1:0]    if_rdata_o,
    input  logic                     dm_req_i,
    input  logic                     dm_we_i,
    input  logic [ADDRESS_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0]    dm_wdata_i,
    output logic                     dm_gnt_o,
    output logic                     dm_rvalid_o,
    output logic [DATA_WIDTH-1:0]    dm_rdata_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
    logic                     owner_dm_q, owner_dm_d;   // 1 = data port owns the transaction
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     if_rvalid_q, if_rvalid_d;
    logic                     dm_rvalid_q, dm_rvalid_d;
    logic [DATA_WIDTH-1:0]    if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]    dm_rdata_q, dm_rdata_d;
    logic                     if_gnt_s, dm_gnt_s;

    // Next-state, arbitration and response-capture logic.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        owner_dm_d   = owner_dm_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rvalid_d  = 1'b0;
        dm_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_gnt_s     = 1'b0;
        dm_gnt_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Data wins unless fetch has been starved for LIMIT contested rounds.
                if (dm_req_i && !(if_req_i && (starve_cnt_q == LIMIT))) begin
                    dm_gnt_s   = 1'b1;
                    owner_dm_d = 1'b1;
                    we_d       = dm_we_i;
                    addr_d     = dm_addr_i;
                    wdata_d    = dm_wdata_i;
                    state_d    = ST_REQ;
                end else if (if_req_i) begin
                    if_gnt_s   = 1'b1;
                    owner_dm_d = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = if_addr_i;
                    wdata_d    = '0;
                    state_d    = ST_REQ;
                end else begin
                    state_d    = ST_IDLE;
                end
                // Only a data win over a waiting fetch counts toward starvation.
                if (dm_gnt_s && if_req_i) begin
                    starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : (starve_cnt_q + CNT_W'(1));
                end else begin
                    starve_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (owner_dm_q) begin
                        dm_rvalid_d = 1'b1;
                        // A store completion carries no data; keep the last load value.
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata_i;
                        end else begin
                            dm_rdata_d = dm_rdata_q;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata_i;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and response registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            owner_dm_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rvalid_q  <= 1'b0;
            dm_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_dm_q   <= owner_dm_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            dm_rvalid_q  <= dm_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // Grants are combinational; masking with rst_i keeps them low while in reset.
    assign if_gnt_o    = if_gnt_s & rst_i;
    assign dm_gnt_o    = dm_gnt_s & rst_i;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Transaction-level reference model plus a bench-side memory. Each cycle the
//   bench drives inputs, samples every DUT output mid-cycle and compares it to
//   the model, then advances the model. Directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int LIM = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = 32'h0, dm_wdata_i = 32'h0;
    logic        dm_gnt_o, dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: one outstanding transaction record.
    bit          m_busy, m_acc, m_own_dm, m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_starve;
    bit          m_if_rv, m_dm_rv;
    logic [31:0] m_if_rd, m_dm_rd;
    logic [31:0] ref_mem [logic [31:0]];
    bit          p_if_gnt, p_dm_gnt;

    // Bench memory, driven from the DUT memory port.
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] env_addr;
    bit          env_we;
    int          gnt_pct = 100, rv_pct = 100, gnt_block = 0;
    bit          stale_en = 1'b0, force_rv = 1'b0;

    // Last sampled outputs for directed scenarios.
    bit          o_if_gnt, o_dm_gnt, o_if_rv, o_dm_rv, o_mem_req, o_mem_we;
    logic [31:0] o_if_rd, o_dm_rd, o_mem_addr, o_mem_wdata;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] env_read(logic [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h100 + (32'($urandom_range(15)) << 2);
    endfunction

    task automatic model_clear();
        m_busy = 1'b0; m_acc = 1'b0; m_starve = 0;
        m_if_rv = 1'b0; m_dm_rv = 1'b0; m_if_rd = 32'h0; m_dm_rd = 32'h0;
        p_if_gnt = 1'b0; p_dm_gnt = 1'b0; gnt_block = 0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        chk("rst_if_gnt", 32'(if_gnt_o), 32'h0);
        chk("rst_dm_gnt", 32'(dm_gnt_o), 32'h0);
        chk("rst_if_rvalid", 32'(if_rvalid_o), 32'h0);
        chk("rst_dm_rvalid", 32'(dm_rvalid_o), 32'h0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_dm_rdata", dm_rdata_o, 32'h0);
        chk("rst_mem_req", 32'(mem_req_o), 32'h0);
        chk("rst_mem_we", 32'(mem_we_o), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    // One clock cycle: drive memory side, compare against model, advance model.
    task automatic cycle();
        bit e_if, e_dm;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
        if (m_busy && !m_acc) begin
            if (gnt_block > 0) gnt_block--;
            else mem_gnt_i = ($urandom_range(99) < gnt_pct);
        end else begin
            mem_gnt_i = ($urandom_range(3) == 0);
        end
        if (m_busy && m_acc) mem_rvalid_i = ($urandom_range(99) < rv_pct);
        else if (force_rv || (stale_en && !mem_gnt_i && $urandom_range(7) == 0)) mem_rvalid_i = 1'b1;
        if (mem_rvalid_i && m_busy && m_acc && !env_we) mem_rdata_i = env_read(env_addr);
        #3;
        o_if_gnt = if_gnt_o; o_dm_gnt = dm_gnt_o; o_if_rv = if_rvalid_o; o_dm_rv = dm_rvalid_o;
        o_mem_req = mem_req_o; o_mem_we = mem_we_o; o_if_rd = if_rdata_o; o_dm_rd = dm_rdata_o;
        o_mem_addr = mem_addr_o; o_mem_wdata = mem_wdata_o;

        e_dm = !m_busy && dm_req_i && !(if_req_i && m_starve == LIM);
        e_if = !m_busy && if_req_i && !e_dm;
        chk("if_gnt", 32'(if_gnt_o), 32'(e_if));
        chk("dm_gnt", 32'(dm_gnt_o), 32'(e_dm));
        chk("mem_req", 32'(mem_req_o), 32'(m_busy && !m_acc));
        if (m_busy && !m_acc) begin
            chk("mem_we", 32'(mem_we_o), 32'(m_we));
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        chk("if_rvalid", 32'(if_rvalid_o), 32'(m_if_rv));
        chk("dm_rvalid", 32'(dm_rvalid_o), 32'(m_dm_rv));
        chk("if_rdata", if_rdata_o, m_if_rd);
        chk("dm_rdata", dm_rdata_o, m_dm_rd);

        if (m_busy && !m_acc && mem_gnt_i) begin
            env_addr = mem_addr_o; env_we = mem_we_o;
            if (mem_we_o) env_mem[mem_addr_o] = mem_wdata_o;
        end

        m_if_rv = 1'b0; m_dm_rv = 1'b0;
        if (m_busy && !m_acc) begin
            if (mem_gnt_i) m_acc = 1'b1;
        end else if (m_busy) begin
            if (mem_rvalid_i) begin
                m_busy = 1'b0; m_acc = 1'b0;
                if (m_own_dm) begin
                    m_dm_rv = 1'b1;
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    else m_dm_rd = ref_read(m_addr);
                end else begin
                    m_if_rv = 1'b1;
                    m_if_rd = ref_read(m_addr);
                end
            end
        end else begin
            m_starve = (e_dm && if_req_i) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
            if (e_dm) begin
                m_busy = 1'b1; m_own_dm = 1'b1; m_we = dm_we_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i;
            end else if (e_if) begin
                m_busy = 1'b1; m_own_dm = 1'b0; m_we = 1'b0; m_addr = if_addr_i; m_wdata = 32'h0;
            end
        end
        p_if_gnt = e_if; p_dm_gnt = e_dm;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_random();
        if (!if_req_i || p_if_gnt) begin
            if_req_i = 1'($urandom_range(1)); if_addr_i = rand_addr();
        end
        if (!dm_req_i || p_dm_gnt) begin
            dm_req_i = 1'($urandom_range(1)); dm_we_i = 1'($urandom_range(1));
            dm_addr_i = rand_addr(); dm_wdata_i = $urandom;
        end
    endtask

    initial begin
        int g_cyc, q_cyc, r_cyc, cnt, ngr, phase;
        logic [31:0] val, seq;
        bit st_we;
        logic [31:0] st_wd;

        model_clear();
        env_mem[32'h10] = 32'h0050_0093;
        ref_mem[32'h10] = 32'h0050_0093;
        #2;
        apply_reset();

        // Single fetch with immediate memory: latency and data.
        if_req_i = 1'b1; if_addr_i = 32'h10;
        g_cyc = -1; q_cyc = -1; r_cyc = -1; cnt = 0; val = 32'h0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (o_if_gnt && g_cyc < 0) g_cyc = i;
            if (o_mem_req && q_cyc < 0) q_cyc = i;
            if (o_if_rv) begin r_cyc = i; val = o_if_rd; end
            if (o_dm_rv) cnt++;
            if (o_if_gnt) if_req_i = 1'b0;
        end
        chk("fetch_gnt_cycle", 32'(g_cyc), 32'd0);
        chk("fetch_memreq_cycle", 32'(q_cyc), 32'd1);
        chk("fetch_rvalid_cycle", 32'(r_cyc), 32'd3);
        chk("fetch_rdata", val, 32'h0050_0093);
        chk("fetch_no_dm_rvalid", 32'(cnt), 32'd0);

        // Store then load of the same address.
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h104; dm_wdata_i = 32'hDEAD_BEEF;
        phase = 0; st_we = 1'b0; st_wd = 32'h0; val = 32'h0;
        for (int i = 0; i < 20 && phase < 2; i++) begin
            cycle();
            if (o_mem_req && phase == 0) begin st_we = o_mem_we; st_wd = o_mem_wdata; end
            if (o_dm_gnt) dm_req_i = 1'b0;
            if (o_dm_rv) begin
                if (phase == 1) val = o_dm_rd;
                phase++;
                if (phase == 1) begin
                    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h104; dm_wdata_i = 32'h0;
                end
            end
        end
        chk("stload_done", 32'(phase), 32'd2);
        chk("store_we", 32'(st_we), 32'd1);
        chk("store_wdata", st_wd, 32'hDEAD_BEEF);
        chk("load_rdata", val, 32'hDEAD_BEEF);

        // Idle with stale responses: nothing must happen.
        stale_en = 1'b1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            cnt += int'(o_mem_req) + int'(o_if_gnt) + int'(o_dm_gnt) + int'(o_if_rv) + int'(o_dm_rv);
        end
        chk("idle_quiet", 32'(cnt), 32'd0);
        stale_en = 1'b0;

        // Contention: both requesters held high continuously.
        if_req_i = 1'b1; if_addr_i = rand_addr();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = rand_addr();
        gnt_pct = 70; rv_pct = 70; ngr = 0; seq = 32'h0;
        for (int i = 0; i < 300 && ngr < 10; i++) begin
            cycle();
            if (o_if_gnt) begin seq[ngr] = 1'b1; ngr++; if_addr_i = rand_addr(); end
            if (o_dm_gnt) begin ngr++; dm_addr_i = rand_addr(); end
        end
        chk("starve_grants", 32'(ngr), 32'd10);
        chk("starve_order", seq, 32'h0000_0210);
        if_req_i = 1'b0; dm_req_i = 1'b0;
        for (int i = 0; i < 40 && m_busy; i++) cycle();
        cycle();

        // Backpressure: memory withholds its grant for 5 cycles.
        gnt_pct = 100; rv_pct = 100;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h108; dm_wdata_i = 32'hCAFE_F00D;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        gnt_block = 5; cnt = 0; phase = 0;
        for (int i = 0; i < 30 && phase < 2; i++) begin
            cycle();
            if (o_mem_req && phase == 0) begin
                cnt++;
                chk("bp_addr_stable", o_mem_addr, 32'h108);
                chk("bp_wdata_stable", o_mem_wdata, 32'hCAFE_F00D);
            end
            if (o_dm_gnt) dm_req_i = 1'b0;
            if (o_if_gnt) if_req_i = 1'b0;
            if (o_dm_rv) phase = 1;
            if (o_if_rv && phase == 1) phase = 2;
        end
        chk("bp_req_cycles", 32'(cnt), 32'd6);
        chk("bp_done", 32'(phase), 32'd2);

        // Reset while waiting for a response, then a late response in IDLE.
        rv_pct = 0;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        for (int i = 0; i < 20 && !(m_busy && m_acc); i++) begin
            cycle();
            if (o_if_gnt) if_req_i = 1'b0;
        end
        chk("rst_reached_wait", 32'(m_busy && m_acc), 32'd1);
        if_req_i = 1'b1; if_addr_i = 32'h10;
        apply_reset();
        rv_pct = 100; force_rv = 1'b1; cnt = 0; val = 32'h0; phase = 0;
        for (int i = 0; i < 12 && phase == 0; i++) begin
            cycle();
            force_rv = 1'b0;
            if (o_if_gnt) if_req_i = 1'b0;
            if (o_if_rv) begin
                if (i < 3) cnt++;
                val = o_if_rd; phase = 1;
            end
        end
        chk("rst_no_early_rvalid", 32'(cnt), 32'd0);
        chk("rst_next_fetch", val, 32'h0050_0093);

        // Randomized traffic with backpressure and stale responses.
        gnt_pct = 50; rv_pct = 50; stale_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end
        if_req_i = 1'b0; dm_req_i = 1'b0; stale_en = 1'b0;
        for (int i = 0; i < 60 && m_busy; i++) cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
